xy_step_arbiter: RTL and testbench

//  Shares one paired x/y step accumulator between two requesters.

---
 rtl/xy_step_arbiter.sv | 72 +++++++
 tb/tb_xy_step_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/xy_step_arbiter.sv
// xy_step_arbiter: two requesters share one paired x/y step accumulator, one step per grant,
// round-robin on ties, locked once the step budget is spent until clr or rst.
module xy_step_arbiter #(
    parameter int WIDTH     = 8,
    parameter int INIT_X    = 5,
    parameter int INIT_Y    = 0,
    parameter int STEP      = 10,
    parameter int MAX_STEPS = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     req,
    input  logic                           clr,
    output logic [1:0]                     grant,
    output logic                           busy,
    output logic                           sat,
    output logic [$clog2(MAX_STEPS+1)-1:0] step_cnt,
    output logic [WIDTH-1:0]               x,
    output logic [WIDTH-1:0]               y
);
    localparam int CW = $clog2(MAX_STEPS + 1);
    typedef enum logic [1:0] {IDLE, EXEC, WAIT, LOCK} state_t;
    state_t state, state_n;
    logic   w, w_n, rr_last;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            w     <= 1'b0;
        end else begin
            state <= state_n;
            w     <= w_n;
        end
    always_comb begin
        state_n = state;
        w_n     = w;
        if (clr)
            state_n = IDLE;
        else
            case (state)
                IDLE:
                    if (step_cnt == CW'(MAX_STEPS))
                        state_n = LOCK;
                    else if (req != 2'b00) begin
                        state_n = EXEC;
                        w_n     = (req == 2'b11) ? ~rr_last : req[1];
                    end
                EXEC:    state_n = WAIT;
                WAIT:    state_n = req[w] ? WAIT : IDLE;
                default: state_n = LOCK;
            endcase
    end
    // clr wins over the EXEC update, so a step in flight is dropped
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            x        <= WIDTH'(INIT_X);
            y        <= WIDTH'(INIT_Y);
            step_cnt <= '0;
            rr_last  <= 1'b1;
        end else if (clr) begin
            x        <= WIDTH'(INIT_X);
            y        <= WIDTH'(INIT_Y);
            step_cnt <= '0;
        end else if (state == EXEC) begin
            x        <= x + WIDTH'(STEP);
            y        <= y + WIDTH'(STEP);
            step_cnt <= step_cnt + CW'(1);
            rr_last  <= w;
        end
    assign grant = (state == EXEC) ? (w ? 2'b10 : 2'b01) : 2'b00;
    assign busy  = state != IDLE;
    assign sat   = state == LOCK;
endmodule

// File: tb/tb_xy_step_arbiter.sv
// tb_xy_step_arbiter: scoreboard bench; expected grant/x/y/step_cnt are queued when a
// request is driven and compared when the grant appears.
module tb_xy_step_arbiter;
    logic       clk = 0, rst = 0, clr = 0, clr4 = 0;
    logic [1:0] req = 0, req4 = 0;
    logic [1:0] grant, grant4;
    logic       busy, sat, busy4, sat4;
    logic [5:0] cnt;
    logic [2:0] cnt4;
    logic [7:0] x, y, x4, y4;
    int         vectors = 0, errs = 0;
    typedef struct {logic [1:0] g; logic [7:0] x; logic [7:0] y; int cnt;} exp_t;
    exp_t       sb[$];
    logic [7:0] mx, my;
    int         mcnt;
    logic       m_rr;

    xy_step_arbiter dut (.clk(clk), .rst(rst), .req(req), .clr(clr), .grant(grant), .busy(busy),
                         .sat(sat), .step_cnt(cnt), .x(x), .y(y));
    xy_step_arbiter #(.MAX_STEPS(4)) dut4 (.clk(clk), .rst(rst), .req(req4), .clr(clr4),
                         .grant(grant4), .busy(busy4), .sat(sat4), .step_cnt(cnt4), .x(x4), .y(y4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("invariant", int'(8'(x - y)), 5);
        chk("never_x20_y0", int'(y == 8'd0 && x == 8'd20), 0);
    end

    task automatic mreset();
        mx = 8'd5; my = 8'd0; mcnt = 0; m_rr = 1'b1;
    endtask

    task automatic push_step(input logic [1:0] g);
        mx = mx + 8'd10;
        my = my + 8'd10;
        mcnt++;
        sb.push_back('{g, mx, my, mcnt});
        m_rr = g[1];
    endtask

    task automatic wait_grant(output bit got);
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = grant != 2'b00;
        end
    endtask

    task automatic serve(input bit rereq);
        exp_t e;
        bit   got;
        logic w;
        chk("sb_nonempty", int'(sb.size() > 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        wait_grant(got);
        chk("grant", int'(grant), int'(e.g));
        if (!got) return;
        @(negedge clk);
        chk("grant_one_cycle", int'(grant), 0);
        chk("busy_wait", int'(busy), 1);
        chk("x", int'(x), int'(e.x));
        chk("y", int'(y), int'(e.y));
        chk("step_cnt", int'(cnt), e.cnt);
        w = e.g[1];
        req[w] = 1'b0;
        @(negedge clk);
        if (rereq) req[w] = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit got;
        int seen;
        #1 rst = 1;
        #1;
        chk("rst_x", int'(x), 5);
        chk("rst_y", int'(y), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk) rst = 0;
        mreset();
        // single requester
        push_step(2'b01);
        req = 2'b01;
        serve(0);
        chk("t2_x", int'(x), 15);
        chk("t2_y", int'(y), 10);
        chk("t2_cnt", int'(cnt), 1);
        // tie rounds from a fresh reset
        rst = 1;
        @(negedge clk) rst = 0;
        mreset();
        for (int i = 0; i < 4; i++) push_step(m_rr ? 2'b01 : 2'b10);
        req = 2'b11;
        for (int i = 0; i < 4; i++) serve(i < 2);
        chk("t3_x", int'(x), 45);
        chk("t3_y", int'(y), 40);
        // wrap
        clr = 1;
        @(negedge clk) clr = 0;
        mreset();
        m_rr = 1'b1;
        chk("clr_x", int'(x), 5);
        chk("clr_cnt", int'(cnt), 0);
        for (int i = 0; i < 26; i++) begin
            push_step(2'b01);
            req = 2'b01;
            serve(0);
            if (i == 24) begin
                chk("t5_x25", int'(x), 255);
                chk("t5_y25", int'(y), 250);
            end
        end
        chk("t5_x26", int'(x), 9);
        chk("t5_y26", int'(y), 4);
        // reset during EXEC
        req = 2'b01;
        wait_grant(got);
        chk("t6_grant_seen", int'(grant), 1);
        #1 rst = 1;
        #1;
        chk("t6_rst_grant", int'(grant), 0);
        chk("t6_rst_x", int'(x), 5);
        chk("t6_rst_y", int'(y), 0);
        chk("t6_rst_busy", int'(busy), 0);
        req = 2'b00;
        @(negedge clk) rst = 0;
        mreset();
        // clr during EXEC
        push_step(2'b01);
        req = 2'b01;
        serve(0);
        req = 2'b01;
        wait_grant(got);
        chk("t6_clr_grant_seen", int'(grant), 1);
        clr = 1;
        @(negedge clk);
        chk("t6_clr_x", int'(x), 5);
        chk("t6_clr_y", int'(y), 0);
        chk("t6_clr_cnt", int'(cnt), 0);
        chk("t6_clr_busy", int'(busy), 0);
        chk("t6_clr_grant", int'(grant), 0);
        clr = 0;
        req = 2'b00;
        // step budget of 4
        for (int i = 0; i < 4; i++) begin
            req4 = 2'b01;
            got = 0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(negedge clk);
                got = grant4 != 2'b00;
            end
            chk("t4_grant", int'(grant4), 1);
            @(negedge clk) req4 = 2'b00;
            @(negedge clk);
        end
        req4 = 2'b01;
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (grant4 != 2'b00) seen++;
        end
        chk("t4_no_grant", seen, 0);
        chk("t4_sat", int'(sat4), 1);
        chk("t4_busy", int'(busy4), 1);
        chk("t4_x", int'(x4), 45);
        chk("t4_y", int'(y4), 40);
        chk("t4_cnt", int'(cnt4), 4);
        clr4 = 1;
        @(negedge clk) clr4 = 0;
        chk("t4_clr_x", int'(x4), 5);
        chk("t4_clr_y", int'(y4), 0);
        chk("t4_clr_sat", int'(sat4), 0);
        chk("t4_clr_cnt", int'(cnt4), 0);
        req4 = 2'b00;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
